// File: rtl/bcd_event_counter_pkg.sv
// Shared widths, counter operation encoding and helper functions for the BCD event counter.
package bcd_event_counter_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned MAX_DIGITS = 4;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_CLEAR,
    OP_INC,
    OP_DEC
  } count_op_e;

  // Segment order {A,B,C,D,E,F,G}, A in the MSB, active-high; non-decimal codes blank.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [BCD_W-1:0] bcd);
    logic [SEG_W-1:0] seg;
    unique case (bcd)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = '0;
    endcase
    return seg;
  endfunction

  // Elaboration-time packing of a decimal constant into MAX_DIGITS BCD nibbles.
  function automatic logic [BCD_W*MAX_DIGITS-1:0] pack_bcd(input int unsigned value);
    logic [BCD_W*MAX_DIGITS-1:0] packed_val;
    int unsigned rest;
    packed_val = '0;
    rest       = value;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      packed_val[i*BCD_W +: BCD_W] = 4'(rest % 10);
      rest = rest / 10;
    end
    return packed_val;
  endfunction

endpackage

// File: rtl/bcd_event_counter_button_debounce.sv
// One push-button path: 2-flop synchroniser, stable-level debouncer, registered rising-edge pulse.
module button_debounce
  import bcd_event_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] stable_cnt_q;
  logic             level_q;
  logic             level_prev_q;
  logic             pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  // Any sample agreeing with the accepted level restarts the run of differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt_q <= '0;
      level_q      <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      stable_cnt_q <= '0;
    end else if (stable_cnt_q == CNT_LAST) begin
      stable_cnt_q <= '0;
      level_q      <= sync_q[1];
    end else begin
      stable_cnt_q <= stable_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      level_prev_q <= level_q;
      pulse_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/bcd_event_counter.sv
// Multi-digit BCD up/down event counter with debounced buttons, wrap/saturate and seven-segment outputs.
module bcd_event_counter
  import bcd_event_counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 2,
  parameter int unsigned MAX_COUNT       = 99,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          WRAP            = 1'b1
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_n,
  input  logic                        i_Inc,
  input  logic                        i_Dec,
  input  logic                        i_Clear,
  output logic [BCD_W*NUM_DIGITS-1:0] o_Digits,
  output logic [SEG_W*NUM_DIGITS-1:0] o_Segments,
  output logic                        o_Carry,
  output logic                        o_Borrow
);

  localparam int unsigned CW = BCD_W * NUM_DIGITS;
  localparam logic [BCD_W*MAX_DIGITS-1:0] MAX_BCD_FULL = pack_bcd(MAX_COUNT);
  localparam logic [CW-1:0] MAX_BCD = MAX_BCD_FULL[CW-1:0];

  logic [1:0]    rst_sync_q;
  logic          rst_int_n;
  logic          inc_pulse, dec_pulse, clr_pulse;
  count_op_e     op;
  logic [CW-1:0] count_q, count_d, inc_val, dec_val;
  logic          carry_q, carry_d, borrow_q, borrow_d;
  logic          inc_ripple, dec_ripple;

  // Reset asserts asynchronously everywhere but releases on a clock edge.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(i_Clk), .rst_n(rst_int_n), .btn_raw(i_Inc),   .press_pulse(inc_pulse)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk(i_Clk), .rst_n(rst_int_n), .btn_raw(i_Dec),   .press_pulse(dec_pulse)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk(i_Clk), .rst_n(rst_int_n), .btn_raw(i_Clear), .press_pulse(clr_pulse)
  );

  always_comb begin
    op = OP_NONE;
    if (clr_pulse) begin
      op = OP_CLEAR;
    end else if (inc_pulse && !dec_pulse) begin
      op = OP_INC;
    end else if (dec_pulse && !inc_pulse) begin
      op = OP_DEC;
    end
  end

  // Per-digit ripple: a digit rolls over only while every lower digit rolled over.
  always_comb begin
    inc_val    = count_q;
    dec_val    = count_q;
    inc_ripple = 1'b1;
    dec_ripple = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (inc_ripple) begin
        if (count_q[i*BCD_W +: BCD_W] == 4'd9) begin
          inc_val[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          inc_val[i*BCD_W +: BCD_W] = count_q[i*BCD_W +: BCD_W] + 4'd1;
          inc_ripple = 1'b0;
        end
      end
      if (dec_ripple) begin
        if (count_q[i*BCD_W +: BCD_W] == 4'd0) begin
          dec_val[i*BCD_W +: BCD_W] = 4'd9;
        end else begin
          dec_val[i*BCD_W +: BCD_W] = count_q[i*BCD_W +: BCD_W] - 4'd1;
          dec_ripple = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    unique case (op)
      OP_CLEAR: count_d = '0;
      OP_INC: begin
        if (count_q != MAX_BCD) begin
          count_d = inc_val;
        end else if (WRAP) begin
          count_d = '0;
          carry_d = 1'b1;
        end
      end
      OP_DEC: begin
        if (count_q != '0) begin
          count_d = dec_val;
        end else if (WRAP) begin
          count_d  = MAX_BCD;
          borrow_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign o_Digits = count_q;
  assign o_Carry  = carry_q;
  assign o_Borrow = borrow_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    assign o_Segments[g*SEG_W +: SEG_W] = seg_decode(count_q[g*BCD_W +: BCD_W]);
  end

endmodule
